// File: rtl/bc_mem_pkg.sv
// Shared types and width helpers for the bc_mem responder.
// Response/request bundles default to a 32-bit data, 32-bit address memory.
package bc_mem_pkg;

  localparam int BC_MEM_DW = 32;
  localparam int BC_MEM_AW = 32;

  typedef struct packed {
    logic [BC_MEM_DW-1:0] rdata;
    logic                 err;
  } bc_mem_rsp_t;

  typedef struct packed {
    logic                   we;
    logic [BC_MEM_AW-1:0]   addr;
    logic [BC_MEM_DW-1:0]   wdata;
    logic [BC_MEM_DW/8-1:0] be;
  } bc_mem_req_t;

  function automatic int bc_mem_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int bc_mem_off_w(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/bc_mem_rsp_fifo.sv
// Synchronous response FIFO; head is visible whenever not empty.
// Pushes to a full FIFO and pops from an empty one are ignored.
module bc_mem_rsp_fifo
  import bc_mem_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = bc_mem_rsp_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr, rd;

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign wr      = i_push & ~o_full;
  assign rd      = i_pop & ~o_empty;
  assign o_head  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    if (rd) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    if (wr && !rd) cnt_d = cnt_q + CW'(1);
    else if (!wr && rd) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem_q[wptr_q] <= i_data;
  end

endmodule

// File: rtl/bc_mem_responder.sv
// Memory responder: word RAM, fixed-latency response pipe, credit-limited FIFO.
// Define BC_MEM_RESPONDER_ERR_EN to flag out-of-range and misaligned accesses.
module bc_mem_responder
  import bc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = BC_MEM_DW,
  parameter int ADDR_WIDTH = BC_MEM_AW,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_be,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic                    o_rsp_err
);

  localparam int NBE   = DATA_WIDTH / 8;
  localparam int IDX_W = bc_mem_idx_w(DEPTH);
  localparam int OFF_W = bc_mem_off_w(DATA_WIDTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] HI_MASK =
    ADDR_WIDTH'(~((64'd1 << (OFF_W + IDX_W)) - 64'd1));

`ifdef BC_MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  acc_err;
  logic                  accept;
  logic                  pop;
  rsp_t                  new_rsp;
  logic                  push;
  rsp_t                  push_rsp;
  rsp_t                  head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign idx     = i_req_addr[OFF_W +: IDX_W];
  assign acc_err = ERR_EN &
                   (((i_req_addr & HI_MASK) != '0) |
                    ((i_req_addr & OFF_MASK) != '0));

  assign o_req_ready = (cnt_q < CNT_W'(RSP_DEPTH));
  assign accept      = i_req_valid & o_req_ready & ~i_rst;
  assign pop         = o_rsp_valid & i_rsp_ready;

  // Read sampled before this cycle's write; one request per cycle keeps order.
  always_comb begin
    new_rsp.err   = acc_err;
    new_rsp.rdata = '0;
    if (!i_req_we && !acc_err) new_rsp.rdata = mem_q[idx];
  end

  always_ff @(posedge i_clk) begin
    if (accept && i_req_we && !acc_err) begin
      for (int b = 0; b < NBE; b++) begin
        if (i_req_be[b]) mem_q[idx][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
      end
    end
  end

  // LATENCY-1 register stages; the FIFO write adds the final cycle.
  if (LATENCY == 1) begin : g_nopipe
    assign push     = accept;
    assign push_rsp = new_rsp;
  end else begin : g_pipe
    logic [LATENCY-2:0] v_q;
    rsp_t               d_q [LATENCY-1];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        v_q <= '0;
      end else begin
        v_q[0] <= accept;
        for (int s = 1; s < LATENCY - 1; s++) v_q[s] <= v_q[s-1];
      end
    end

    always_ff @(posedge i_clk) begin
      d_q[0] <= new_rsp;
      for (int s = 1; s < LATENCY - 1; s++) d_q[s] <= d_q[s-1];
    end

    assign push     = v_q[LATENCY-2];
    assign push_rsp = d_q[LATENCY-2];
  end

  bc_mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (push_rsp),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_rsp_valid = ~fifo_empty;
  assign o_rsp_rdata = o_rsp_valid ? head.rdata : '0;
  assign o_rsp_err   = o_rsp_valid ? head.err : 1'b0;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Credits guarantee the FIFO can always absorb the pipeline exit.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (!(push && fifo_full && !pop));
  end

endmodule

// File: tb/tb_bc_mem_responder.sv
// Scoreboard bench for bc_mem_responder (LATENCY=2, RSP_DEPTH=4, DEPTH=1024).
// Builds with or without BC_MEM_RESPONDER_ERR_EN.
module tb_bc_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  bc_mem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (1024),
    .LATENCY    (LAT),
    .RSP_DEPTH  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_be    (req_be),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [1024];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          exact_mode = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
`ifdef BC_MEM_RESPONDER_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int tries, output bit acc);
    exp_t        e;
    logic [9:0]  idx;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    acc       = 1'b0;
    for (int t = 0; t < tries && !acc; t++) begin
      @(negedge clk);
      if (req_ready) begin
        acc     = 1'b1;
        idx     = addr[11:2];
        e.err   = exp_err(addr);
        e.acc   = cyc;
        e.exact = exact_mode;
        e.rdata = 32'h0;
        if (we) begin
          if (!e.err)
            for (int b = 0; b < 4; b++)
              if (be[b]) mdl[idx][b*8 +: 8] = wdata[b*8 +: 8];
        end else if (!e.err) begin
          e.rdata = mdl[idx];
        end
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    bit ok;
    issue(1'b1, a, d, be, 50, ok);
    chk("wr_accept", 32'(ok), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a);
    bit ok;
    issue(1'b0, a, 32'h0, 4'h0, 50, ok);
    chk("rd_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain;
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: pops expected responses and checks stability while stalled.
  logic [31:0] held_rdata;
  logic        held_err;
  bit          stalled = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (rsp_valid && stalled) begin
        chk("stall_rdata", rsp_rdata, held_rdata);
        chk("stall_err", 32'(rsp_err), 32'(held_err));
      end
      if (rsp_valid && rsp_ready) begin
        stalled = 1'b0;
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.exact) chk("rsp_latency", 32'(cyc - e.acc), 32'(LAT));
          else chk("rsp_min_lat", 32'(cyc - e.acc >= LAT), 32'd1);
        end
      end else if (rsp_valid) begin
        stalled    = 1'b1;
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    int nacc;
    bit ok;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    // reset held three cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    // word 0 seeded for the alias/error checks
    wr(32'h0, 32'h11223344, 4'hF);
    drain();

    // write then read back-to-back
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);
    drain();

    // partial write of byte 1
    wr(32'h10, 32'h0000AA00, 4'b0010);
    rd(32'h10);
    drain();
    chk("model_partial", mdl[4], 32'hDEADAAEF);

    // streaming: 16 writes then 16 reads, one per cycle
    for (int i = 0; i < 16; i++)
      wr(32'h100 + 32'(i * 4), (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5, 4'hF);
    for (int i = 0; i < 16; i++) rd(32'h100 + 32'(i * 4));
    drain();

    // back-pressure: only four credits
    exact_mode = 1'b0;
    rsp_ready  = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, 1, ok);
      nacc += int'(ok);
    end
    chk("bp_accepted", 32'(nacc), 32'd4);
    @(negedge clk);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    exact_mode = 1'b1;

    // error / alias handling
    rd(32'h2);
    rd(32'h1000);
    wr(32'h1000, 32'hCAFEF00D, 4'hF);
    rd(32'h0);
    drain();
`ifdef BC_MEM_RESPONDER_ERR_EN
    chk("model_word0_kept", mdl[0], 32'h11223344);
`else
    chk("model_word0_alias", mdl[0], 32'hCAFEF00D);
`endif

    // reset with buffered responses
    rsp_ready = 1'b0;
    rd(32'h10);
    rd(32'h104);
    rd(32'h108);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rd(32'h10);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
